pulse_width_stats: RTL and testbench
====================================

Name: pulse_width_stats

Overview:
Downstream consumer of the pulse-width measurement stage. Takes one measured width per strobe and accumulates statistics over a fixed window of 2^LOG2_N pulses. At the end of each window it publishes the minimum, maximum and truncated average width. It also keeps a total pulse count and a sticky over-threshold flag for the monitoring/status logic.

Parameters:
LOG2_N, 3, log2 of window size; window N = 2^LOG2_N pulses; legal range 1..8
LONG_THRESH, 16'd1000, width strictly greater than this sets long_flag

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
width_in  input  16  measured pulse width in clk cycles
width_valid  input  1  single-cycle strobe; width_in sampled when high
clear  input  1  synchronous clear of all statistics
min_width  output  16  minimum width of last completed window
max_width  output  16  maximum width of last completed window
avg_width  output  16  truncated mean of last completed window
stats_valid  output  1  one-cycle pulse when min/max/avg update
window_count  output  16  completed windows, wraps FFFF->0000
pulse_count  output  32  accepted samples total, saturates at FFFFFFFF
long_flag  output  1  sticky: some accepted width > LONG_THRESH

Behaviour:
- Reset (async, rst=1): all outputs 0; running sum 0, running min 16'hFFFF, running max 0, sample counter 0, FSM to IDLE.
- Accepted sample: width_valid=1 and width_in!=0. A zero width is ignored: no counter, flag or statistics change.
- FSM states:
  - IDLE: window empty. An accepted sample goes to ACCUM, or directly to PUBLISH when N=2^LOG2_N=1 is not legal, so that case never occurs.
  - ACCUM: per accepted sample: sum += width_in, min = min(min,width_in), max = max(max,width_in), samp_cnt++. The sample that makes samp_cnt reach N goes to PUBLISH.
  - PUBLISH: lasts one cycle, then returns to IDLE.
- Publish timing:
  - On the edge that accepts the Nth sample, the final sum, min and max (including that sample) are registered to the outputs. avg_width = final_sum >> LOG2_N.
  - stats_valid=1 during the cycle after that edge, so latency is 1 cycle. window_count increments on the same edge.
  - The running accumulators reinitialise on that same edge. A sample accepted during PUBLISH is counted as the first sample of the next window; it is not lost. The FSM then moves to ACCUM rather than IDLE.
- Arithmetic:
  - Running sum is 16+LOG2_N bits, so overflow is impossible.
  - Average is truncated (floor) and always fits in 16 bits.
- Published outputs hold their values until the next publish, clear, or reset.
- pulse_count: +1 per accepted sample, saturates at FFFFFFFF.
- long_flag: set on any accepted width > LONG_THRESH (strict). Equality does not set it. Stays set until clear or rst.
- clear=1 (synchronous):
  - Next edge clears all outputs and accumulators to their reset values and sets the FSM to IDLE.
  - clear has priority over a simultaneous width_valid; that sample is dropped.
  - clear arriving on the completing edge suppresses the publish, so stats_valid stays 0.
- rst mid-window discards the partial window; no publish occurs.
- width_valid held high for consecutive cycles: each cycle is an independent sample.

Test Plan:
- LOG2_N=2; widths 3,5,7,9 on consecutive strobes -> one cycle after 9 is accepted: stats_valid=1 for exactly 1 cycle, min=3, max=9, avg=6, window_count=1, pulse_count=4.
- LOG2_N=2; widths 1,1,1,2 -> avg=1 (5>>2, truncated), min=1, max=2; then widths 0,0 interleaved -> pulse_count unchanged by the zeros, no publish.
- LOG2_N=2; 8 back-to-back strobes of 16'hFFFF -> two stats_valid pulses 4 cycles apart; avg=FFFF (no overflow); window_count=2; long_flag=1.
- Widths 1000 then 1001 (LONG_THRESH=1000) -> long_flag=0 after the first, 1 after the second; clear -> long_flag=0, all outputs 0.
- LOG2_N=2; 3 samples, then rst pulse, then 4 samples 2,2,2,2 -> a single publish with avg=2; window_count=1.
- clear asserted together with the 4th sample -> no stats_valid, outputs 0; next 4 samples 4,4,4,4 -> publish with min=max=avg=4.

Source files
------------

// File: rtl/pulse_width_stats.sv
// Windowed pulse-width statistics: min/max/floor-average over 2^LOG2_N accepted
// samples, plus a lifetime sample count and a sticky over-threshold flag.
module pulse_width_stats #(
    parameter int          LOG2_N      = 3,
    parameter logic [15:0] LONG_THRESH = 16'd1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] width_in,
    input  logic        width_valid,
    input  logic        clear,
    output logic [15:0] min_width,
    output logic [15:0] max_width,
    output logic [15:0] avg_width,
    output logic        stats_valid,
    output logic [15:0] window_count,
    output logic [31:0] pulse_count,
    output logic        long_flag
);
    localparam int SW = 16 + LOG2_N;
    localparam int CW = LOG2_N;
    localparam logic [CW-1:0] LAST_IDX = CW'((1 << LOG2_N) - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        PUBLISH
    } state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  sum_q, sum_d;
    logic [15:0]    run_min_q, run_min_d;
    logic [15:0]    run_max_q, run_max_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [15:0]    min_width_q, min_width_d;
    logic [15:0]    max_width_q, max_width_d;
    logic [15:0]    avg_width_q, avg_width_d;
    logic           stats_valid_q, stats_valid_d;
    logic [15:0]    window_count_q, window_count_d;
    logic [31:0]    pulse_count_q, pulse_count_d;
    logic           long_flag_q, long_flag_d;

    logic           accept;
    logic [SW-1:0]  sum_new;
    logic [15:0]    min_new;
    logic [15:0]    max_new;

    // Zero-width strobes carry no measurement and are dropped entirely.
    assign accept  = width_valid && (width_in != 16'd0);
    assign sum_new = sum_q + SW'(width_in);
    assign min_new = (width_in < run_min_q) ? width_in : run_min_q;
    assign max_new = (width_in > run_max_q) ? width_in : run_max_q;

    always_comb begin
        state_d        = state_q;
        sum_d          = sum_q;
        run_min_d      = run_min_q;
        run_max_d      = run_max_q;
        cnt_d          = cnt_q;
        min_width_d    = min_width_q;
        max_width_d    = max_width_q;
        avg_width_d    = avg_width_q;
        stats_valid_d  = 1'b0;
        window_count_d = window_count_q;
        pulse_count_d  = pulse_count_q;
        long_flag_d    = long_flag_q;

        if (clear) begin
            state_d        = IDLE;
            sum_d          = '0;
            run_min_d      = 16'hFFFF;
            run_max_d      = 16'h0000;
            cnt_d          = '0;
            min_width_d    = 16'h0000;
            max_width_d    = 16'h0000;
            avg_width_d    = 16'h0000;
            window_count_d = 16'h0000;
            pulse_count_d  = 32'h0000_0000;
            long_flag_d    = 1'b0;
        end else if (accept) begin
            if (pulse_count_q != 32'hFFFF_FFFF) begin
                pulse_count_d = pulse_count_q + 32'd1;
            end
            if (width_in > LONG_THRESH) begin
                long_flag_d = 1'b1;
            end
            if (cnt_q == LAST_IDX) begin
                // Completing sample: publish including it, and restart the window
                // so a sample arriving during PUBLISH opens the next one.
                min_width_d    = min_new;
                max_width_d    = max_new;
                avg_width_d    = 16'(sum_new >> LOG2_N);
                stats_valid_d  = 1'b1;
                window_count_d = window_count_q + 16'd1;
                sum_d          = '0;
                run_min_d      = 16'hFFFF;
                run_max_d      = 16'h0000;
                cnt_d          = '0;
                state_d        = PUBLISH;
            end else begin
                sum_d     = sum_new;
                run_min_d = min_new;
                run_max_d = max_new;
                cnt_d     = cnt_q + CW'(1);
                state_d   = ACCUM;
            end
        end else if (state_q == PUBLISH) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            sum_q          <= '0;
            run_min_q      <= 16'hFFFF;
            run_max_q      <= 16'h0000;
            cnt_q          <= '0;
            min_width_q    <= 16'h0000;
            max_width_q    <= 16'h0000;
            avg_width_q    <= 16'h0000;
            stats_valid_q  <= 1'b0;
            window_count_q <= 16'h0000;
            pulse_count_q  <= 32'h0000_0000;
            long_flag_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            sum_q          <= sum_d;
            run_min_q      <= run_min_d;
            run_max_q      <= run_max_d;
            cnt_q          <= cnt_d;
            min_width_q    <= min_width_d;
            max_width_q    <= max_width_d;
            avg_width_q    <= avg_width_d;
            stats_valid_q  <= stats_valid_d;
            window_count_q <= window_count_d;
            pulse_count_q  <= pulse_count_d;
            long_flag_q    <= long_flag_d;
        end
    end

    assign min_width    = min_width_q;
    assign max_width    = max_width_q;
    assign avg_width    = avg_width_q;
    assign stats_valid  = stats_valid_q;
    assign window_count = window_count_q;
    assign pulse_count  = pulse_count_q;
    assign long_flag    = long_flag_q;

endmodule

// File: tb/tb_pulse_width_stats.sv
// Randomized + directed bench for pulse_width_stats with a window-queue reference
// model; publish records go through a scoreboard queue checked by a monitor.
module tb_pulse_width_stats;
    localparam int LOG2_N = 2;
    localparam int N      = 1 << LOG2_N;
    localparam int THRESH = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] width_in = 16'd0;
    logic        width_valid = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] min_width, max_width, avg_width, window_count;
    logic        stats_valid, long_flag;
    logic [31:0] pulse_count;

    pulse_width_stats #(.LOG2_N(LOG2_N), .LONG_THRESH(16'd1000)) dut (
        .clk(clk), .rst(rst), .width_in(width_in), .width_valid(width_valid),
        .clear(clear), .min_width(min_width), .max_width(max_width),
        .avg_width(avg_width), .stats_valid(stats_valid),
        .window_count(window_count), .pulse_count(pulse_count),
        .long_flag(long_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned mn, mx, av, wc, pc;
    } pub_t;

    pub_t        sb[$];
    int unsigned win[$];
    int unsigned m_min, m_max, m_avg, m_wc, m_pc;
    bit          m_flag;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        win.delete();
        m_min = 0; m_max = 0; m_avg = 0; m_wc = 0; m_pc = 0; m_flag = 0;
    endtask

    // Reference behaviour: collect accepted widths, summarise when N are held.
    task automatic model_step(input bit v, input int unsigned w, input bit c);
        longint unsigned s;
        pub_t p;
        if (c) begin
            model_reset();
        end else if (v && w != 0) begin
            if (m_pc != 32'hFFFF_FFFF) m_pc++;
            if (w > THRESH) m_flag = 1;
            win.push_back(w);
            if (win.size() == N) begin
                s = 0; m_min = 16'hFFFF; m_max = 0;
                foreach (win[i]) begin
                    s += win[i];
                    if (win[i] < m_min) m_min = win[i];
                    if (win[i] > m_max) m_max = win[i];
                end
                m_avg = int'(s / N);
                m_wc  = (m_wc + 1) & 16'hFFFF;
                p.mn = m_min; p.mx = m_max; p.av = m_avg; p.wc = m_wc; p.pc = m_pc;
                sb.push_back(p);
                win.delete();
            end
        end
    endtask

    task automatic apply(input bit v, input logic [15:0] w, input bit c);
        width_valid = v; width_in = w; clear = c;
        @(posedge clk);
        model_step(v, w, c);
        #1;
        width_valid = 0; clear = 0; width_in = 0;
    endtask

    task automatic pulse_reset();
        #1 rst = 1'b1;
        model_reset();
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: publish records are popped only when the DUT flags them.
    always @(negedge clk) begin
        pub_t p;
        if (stats_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_stats_valid", 1, 0);
            end else begin
                p = sb.pop_front();
                check("pub_min", min_width, p.mn);
                check("pub_max", max_width, p.mx);
                check("pub_avg", avg_width, p.av);
                check("pub_wcount", window_count, p.wc);
                check("pub_pcount", pulse_count, p.pc);
            end
        end
        check("min_width", min_width, m_min);
        check("max_width", max_width, m_max);
        check("avg_width", avg_width, m_avg);
        check("window_count", window_count, m_wc);
        check("pulse_count", pulse_count, m_pc);
        check("long_flag", long_flag, m_flag);
    end

    initial begin
        int unsigned r;
        logic [15:0] w;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 3,5,7,9 -> min 3 max 9 avg 6
        apply(1, 3, 0); apply(1, 5, 0); apply(1, 7, 0); apply(1, 9, 0);
        apply(0, 0, 0); apply(0, 0, 0);
        // 1,1,1,2 -> avg 1 (truncation), zeros interleaved
        apply(1, 1, 0); apply(1, 0, 0); apply(1, 1, 0); apply(1, 1, 0);
        apply(1, 2, 0); apply(1, 0, 0); apply(0, 0, 0); apply(1, 0, 0);
        // 8 back-to-back FFFF -> two publishes, avg FFFF
        for (int i = 0; i < 8; i++) apply(1, 16'hFFFF, 0);
        apply(0, 0, 0);
        // threshold equality then strict exceed, then clear
        apply(0, 0, 1);
        apply(1, 1000, 0); apply(0, 0, 0);
        apply(1, 1001, 0); apply(0, 0, 0);
        apply(0, 0, 1); apply(0, 0, 0);
        // partial window discarded by reset
        apply(1, 6, 0); apply(1, 6, 0); apply(1, 6, 0);
        pulse_reset();
        for (int i = 0; i < 4; i++) apply(1, 2, 0);
        apply(0, 0, 0);
        // clear coinciding with completing sample suppresses publish
        apply(1, 7, 0); apply(1, 7, 0); apply(1, 7, 0); apply(1, 7, 1);
        apply(0, 0, 0);
        for (int i = 0; i < 4; i++) apply(1, 4, 0);
        apply(0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 99);
            case ($urandom_range(0, 3))
                0: w = 16'd0;
                1: w = 16'(995 + $urandom_range(0, 10));
                2: w = 16'(65530 + $urandom_range(0, 5));
                default: w = 16'($urandom_range(1, 2000));
            endcase
            if (r < 2) apply(0, 0, 1);
            else if (r < 4) apply(1, w, 1);
            else if (r < 70) apply(1, w, 0);
            else apply(0, w, 0);
            if ($urandom_range(0, 299) == 0) pulse_reset();
        end
        repeat (3) apply(0, 0, 0);
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
